// File: rtl/ntt_pkg.sv
// Kyber NTT constants and the canonical mod-Q add/sub helpers shared by the butterfly datapath.
package ntt_pkg;
  localparam int DW        = 12;
  localparam int Q         = 3329;
  localparam int BARRETT_M = 5039;
  localparam int BARRETT_K = 24;

  localparam logic MODE_CT = 1'b0;
  localparam logic MODE_GS = 1'b1;

  localparam logic [DW:0] Q_EXT = Q[DW:0];

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= Q_EXT) s = s - Q_EXT;
    return DW'(s);
  endfunction

  // A borrow wraps the DW+1 result; adding Q brings it back into [0, Q).
  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + Q_EXT;
    return DW'(d);
  endfunction
endpackage

// File: rtl/mod_mul_barrett.sv
// Modular multiply x*w mod Q: product register, then Barrett reduction register (2 cycles).
// Stages advance only on i_en; valid and sideband travel alongside the data.
module mod_mul_barrett
  import ntt_pkg::*;
#(
  parameter int SW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_vld,
  input  logic [DW-1:0] i_x,
  input  logic [DW-1:0] i_w,
  input  logic [SW-1:0] i_sb,
  output logic          o_vld,
  output logic [DW-1:0] o_r,
  output logic [SW-1:0] o_sb
);
  localparam int PW = 2 * DW;
  localparam int MW = 13;
  localparam logic [MW-1:0] BM   = BARRETT_M[MW-1:0];
  localparam logic [DW-1:0] Q_DW = Q[DW-1:0];

  logic          r_v3;
  logic [PW-1:0] r_p;
  logic [SW-1:0] r_sb3;
  logic          r_v4;
  logic [DW-1:0] r_r4;
  logic [SW-1:0] r_sb4;

  logic [PW+MW-1:0] w_pm;
  logic [DW-1:0]    w_t;
  logic [PW-1:0]    w_tq;
  logic [DW:0]      w_r13;
  logic [DW-1:0]    w_r;

  // Quotient estimate undershoots by at most one Q, so a single correction suffices.
  always_comb begin
    w_pm  = {{MW{1'b0}}, r_p} * {{PW{1'b0}}, BM};
    w_t   = DW'(w_pm >> BARRETT_K);
    w_tq  = {{DW{1'b0}}, w_t} * {{(PW-DW){1'b0}}, Q_DW};
    w_r13 = (DW+1)'(r_p - w_tq);
    w_r   = (w_r13 >= Q_EXT) ? DW'(w_r13 - Q_EXT) : w_r13[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3  <= 1'b0;
      r_p   <= '0;
      r_sb3 <= '0;
      r_v4  <= 1'b0;
      r_r4  <= '0;
      r_sb4 <= '0;
    end else if (i_en) begin
      r_v3  <= i_vld;
      r_p   <= {{DW{1'b0}}, i_x} * {{DW{1'b0}}, i_w};
      r_sb3 <= i_sb;
      r_v4  <= r_v3;
      r_r4  <= w_r;
      r_sb4 <= r_sb3;
    end
  end

  assign o_vld = r_v4;
  assign o_r   = r_r4;
  assign o_sb  = r_sb4;
endmodule

// File: rtl/bf_unit_pipe.sv
// Kyber radix-2 butterfly (CT forward / GS inverse), 5 register stages, result 4 edges after accept.
// Whole pipe stalls while a result is held unread; in_ready mirrors the global advance enable.
module bf_unit_pipe
  import ntt_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mode,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic [DW-1:0] w_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] u_out,
  output logic [DW-1:0] v_out
);
  logic          w_en;
  logic          r_v1, r_mode1;
  logic [DW-1:0] r_a, r_b, r_w1;
  logic          r_v2, r_mode2;
  logic [DW-1:0] r_x, r_w2, r_pass2;
  logic          r_v5;
  logic [DW-1:0] r_u, r_v;

  logic [DW-1:0] w_x, w_pass;
  logic          w_v4;
  logic [DW-1:0] w_r4;
  logic [DW:0]   w_sb4;
  logic [DW-1:0] w_u5, w_v5;

  assign w_en     = !r_v5 || out_ready;
  assign in_ready = w_en;

  always_comb begin
    w_x    = r_b;
    w_pass = r_a;
    if (r_mode1 == MODE_GS) begin
      w_x    = mod_sub(r_a, r_b);
      w_pass = mod_add(r_a, r_b);
    end
  end

  mod_mul_barrett #(.SW(DW + 1)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_en),
    .i_vld (r_v2),
    .i_x   (r_x),
    .i_w   (r_w2),
    .i_sb  ({r_mode2, r_pass2}),
    .o_vld (w_v4),
    .o_r   (w_r4),
    .o_sb  (w_sb4)
  );

  always_comb begin
    w_u5 = w_sb4[DW-1:0];
    w_v5 = w_r4;
    if (w_sb4[DW] == MODE_CT) begin
      w_u5 = mod_add(w_sb4[DW-1:0], w_r4);
      w_v5 = mod_sub(w_sb4[DW-1:0], w_r4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_mode1 <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_w1    <= '0;
      r_v2    <= 1'b0;
      r_mode2 <= 1'b0;
      r_x     <= '0;
      r_w2    <= '0;
      r_pass2 <= '0;
      r_v5    <= 1'b0;
      r_u     <= '0;
      r_v     <= '0;
    end else if (w_en) begin
      r_v1    <= in_valid;
      r_mode1 <= mode;
      r_a     <= a_in;
      r_b     <= b_in;
      r_w1    <= w_in;
      r_v2    <= r_v1;
      r_mode2 <= r_mode1;
      r_x     <= w_x;
      r_w2    <= r_w1;
      r_pass2 <= w_pass;
      r_v5    <= w_v4;
      r_u     <= w_u5;
      r_v     <= w_v5;
    end
  end

  assign out_valid = r_v5;
  assign u_out     = r_u;
  assign v_out     = r_v;
endmodule

// File: tb/tb_bf_unit_pipe.sv
// Directed and streamed checks of the Kyber butterfly pipe against a plain mod-Q reference.
module tb_bf_unit_pipe;
  localparam int Q = 3329;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [11:0] a_in, b_in, w_in;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] u_out, v_out;

  int n_chk = 0;
  int n_err = 0;
  logic [23:0] exp_q[$];

  bf_unit_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a_in      (a_in),
    .b_in      (b_in),
    .w_in      (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .u_out     (u_out),
    .v_out     (v_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mq(input int x);
    return ((x % Q) + Q) % Q;
  endfunction

  function automatic logic [23:0] model(input logic md, input int a, input int b, input int w);
    int u, v, t;
    if (md == 1'b0) begin
      t = (b * w) % Q;
      u = mq(a + t);
      v = mq(a - t);
    end else begin
      u = mq(a + b);
      v = mq(mq(a - b) * w);
    end
    return {u[11:0], v[11:0]};
  endfunction

  // Single beat into an idle pipe; latency counts the accepting edge as edge 1.
  task automatic run_one(input string tag, input logic md, input int a, input int b, input int w,
                         input int eu, input int ev);
    int lat;
    bit got;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    mode      = md;
    a_in      = 12'(a);
    b_in      = 12'(b);
    w_in      = 12'(w);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    while (!got && lat < 20) begin
      if (out_valid) got = 1'b1;
      else begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    chk({tag, "_lat"}, lat, 5);
    chk({tag, "_u"}, int'(u_out), eu);
    chk({tag, "_v"}, int'(v_out), ev);
  endtask

  // Random stream with scoreboard; hold_at forces out_ready low for 3 cycles.
  task automatic stream(input string tag, input int nbeats, input int vld_pct, input int rdy_pct,
                        input int hold_at, output bit saw_stall);
    int sent, cyc, a, b, w;
    bit prev_stall;
    logic [11:0] pu, pv;
    logic [23:0] e;
    sent = 0;
    cyc = 0;
    prev_stall = 1'b0;
    saw_stall = 1'b0;
    pu = '0;
    pv = '0;
    while ((sent < nbeats || exp_q.size() > 0) && cyc < nbeats * 10 + 100) begin
      @(negedge clk);
      if (prev_stall) begin
        chk({tag, "_hold_vld"}, int'(out_valid), 1);
        chk({tag, "_hold_u"}, int'(u_out), int'(pu));
        chk({tag, "_hold_v"}, int'(v_out), int'(pv));
      end
      if (out_valid) begin
        chk({tag, "_u_lt_q"}, int'(u_out < 12'd3329), 1);
        chk({tag, "_v_lt_q"}, int'(v_out < 12'd3329), 1);
      end
      if (hold_at >= 0 && cyc >= hold_at && cyc < hold_at + 3) out_ready = 1'b0;
      else if (sent >= nbeats) out_ready = 1'b1;
      else out_ready = ($urandom_range(99) < rdy_pct);
      in_valid = (sent < nbeats) && ($urandom_range(99) < vld_pct);
      mode = 1'($urandom_range(1));
      a = $urandom_range(Q - 1);
      b = $urandom_range(Q - 1);
      w = $urandom_range(Q - 1);
      a_in = 12'(a);
      b_in = 12'(b);
      w_in = 12'(w);
      #1;
      if (!in_ready) saw_stall = 1'b1;
      chk({tag, "_in_ready"}, int'(in_ready), int'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk({tag, "_spurious"}, 1, 0);
        else begin
          e = exp_q.pop_front();
          chk({tag, "_u"}, int'(u_out), int'(e[23:12]));
          chk({tag, "_v"}, int'(v_out), int'(e[11:0]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(mode, a, b, w));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      pu = u_out;
      pv = v_out;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_sent"}, sent, nbeats);
    exp_q.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stalled;
    int bad;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    mode = 1'b0;
    a_in = '0;
    b_in = '0;
    w_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_u", int'(u_out), 0);
    chk("rst_v", int'(v_out), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);

    run_one("gs_small", 1'b1, 5, 10, 1, 15, 3324);
    run_one("ct_small", 1'b0, 0, 1, 3328, 3328, 1);
    run_one("gs_max", 1'b1, 3328, 3328, 3328, 3327, 0);
    run_one("ct_max", 1'b0, 3328, 3328, 3328, 0, 3327);
    run_one("gs_wrap", 1'b1, 1000, 2329, 7, 0, 684);
    run_one("gs_eq", 1'b1, 777, 777, 1234, 1554, 0);
    run_one("ct_w0", 1'b0, 1234, 555, 0, 1234, 1234);
    run_one("gs_w0", 1'b1, 100, 3000, 0, 3100, 0);

    stream("bp", 8, 100, 100, 4, stalled);
    chk("bp_in_ready_dropped", int'(stalled), 1);

    // Three beats in flight, the oldest already presented, then reset mid-cycle.
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      mode = 1'b0;
      a_in = 12'(10 + i);
      b_in = 12'd20;
      w_in = 12'd30;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_out_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_u", int'(u_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    run_one("post_rst", 1'b1, 5, 10, 1, 15, 3324);

    stream("rand", 10000, 70, 70, -1, stalled);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
